// File: rtl/panel_pkg.sv
// Shared types and default parameters for the front-panel switch controller.
// The event record is sized for the widest supported panel (16 channels).
package panel_pkg;

  localparam int N_DEF         = 8;
  localparam int DIV_W_DEF     = 15;
  localparam int STABLE_DEF    = 4;
  localparam int DEPTH_DEF     = 4;
  localparam int POR_TICKS_DEF = 10;

  localparam int CODE_MAX_W = 4;

  typedef struct packed {
    logic [CODE_MAX_W-1:0] code;
    logic                  press;
  } ev_t;

  localparam int EV_W = $bits(ev_t);

endpackage

// File: rtl/panel_ev_fifo.sv
// Small synchronous event FIFO; head is read combinationally from the storage.
// A push is dropped whenever the FIFO is full, even if a pop happens that cycle.
module panel_ev_fifo
  import panel_pkg::*;
#(
  parameter int W     = EV_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/panel_switch_ctrl.sv
// Front-panel switch controller: synchronize, debounce on a shared tick, queue
// press/release events round-robin into a FIFO, and hold the CPU in power-on reset.
module panel_switch_ctrl
  import panel_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int STABLE    = STABLE_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int POR_TICKS = POR_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         sw,
  output logic [N-1:0]         sw_state,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [$clog2(N)-1:0] ev_code,
  output logic                 ev_press,
  output logic                 ev_overflow,
  input  logic                 ov_clear,
  output logic                 por_out
);

  localparam int CODE_W = $clog2(N);
  localparam int CNT_W  = $clog2(STABLE + 1);
  localparam int POR_W  = $clog2(POR_TICKS + 1);

  logic [N-1:0]       sync1_q, sync1_d;
  logic [N-1:0]       sync2_q, sync2_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [N-1:0]       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [N];
  logic [CNT_W-1:0]   cnt_d [N];
  logic [N-1:0]       pend_q, pend_d;
  logic [N-1:0]       pol_q, pol_d;
  logic [CODE_W-1:0]  rr_q, rr_d;
  logic               ov_q, ov_d;
  logic               por_q, por_d;
  logic [POR_W-1:0]   por_cnt_q, por_cnt_d;

  logic               tick;
  logic [N-1:0]       toggle;
  logic               gnt_found;
  logic [CODE_W-1:0]  gnt_idx;
  logic [CODE_W-1:0]  cand;
  int                 idx;
  logic [N-1:0]       gnt_mask;
  logic               push;
  logic               ov_set;
  logic               fifo_full;
  logic               fifo_empty;
  ev_t                push_ev;
  ev_t                head_ev;
  logic               unused_code;

  assign sync1_d = sw;
  assign sync2_d = sync1_q;
  assign div_d   = div_q + 1'b1;
  assign tick    = &div_q;

  // Debounce: a channel flips only after STABLE consecutive ticks disagreeing.
  always_comb begin
    state_d = state_q;
    toggle  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != state_q[i]) begin
          if (cnt_q[i] == CNT_W'(STABLE - 1)) begin
            toggle[i]  = 1'b1;
            state_d[i] = ~state_q[i];
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Round-robin search starting at rr_q; works on registered pend so a new
  // toggle is granted one cycle after it is accepted.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      cand = CODE_W'(idx);
      if (!gnt_found && pend_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign push = gnt_found && !fifo_full;

  always_comb begin
    gnt_mask = '0;
    rr_d     = rr_q;
    if (push) begin
      gnt_mask[gnt_idx] = 1'b1;
      rr_d = (gnt_idx == CODE_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
    push_ev.code  = CODE_MAX_W'(gnt_idx);
    push_ev.press = pol_q[gnt_idx];
  end

  // A fresh toggle beats a same-cycle grant clear; it only counts as a lost
  // event when the earlier one is still waiting and not being pushed now.
  always_comb begin
    pend_d = pend_q & ~gnt_mask;
    pol_d  = pol_q;
    ov_set = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (toggle[i]) begin
        pend_d[i] = 1'b1;
        pol_d[i]  = state_d[i];
        if (pend_q[i] && !gnt_mask[i]) begin
          ov_set = 1'b1;
        end
      end
    end
    ov_d = ov_set | (ov_q & ~ov_clear);
  end

  always_comb begin
    por_d     = por_q;
    por_cnt_d = por_cnt_q;
    if (por_q && tick) begin
      por_cnt_d = por_cnt_q + 1'b1;
      if (por_cnt_q == POR_W'(POR_TICKS - 1)) begin
        por_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      div_q     <= '0;
      state_q   <= '0;
      pend_q    <= '0;
      pol_q     <= '0;
      rr_q      <= '0;
      ov_q      <= 1'b0;
      por_q     <= 1'b1;
      por_cnt_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      state_q   <= state_d;
      pend_q    <= pend_d;
      pol_q     <= pol_d;
      rr_q      <= rr_d;
      ov_q      <= ov_d;
      por_q     <= por_d;
      por_cnt_q <= por_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  // Event port: valid/ready; the head transfers on a cycle where both are high,
  // and while valid is high without ready the head holds and valid stays up.
  panel_ev_fifo #(
    .W     (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (push_ev),
    .pop       (ev_valid && ev_ready),
    .head      (head_ev),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid    = !fifo_empty;
  assign ev_code     = head_ev.code[CODE_W-1:0];
  assign ev_press    = head_ev.press;
  assign unused_code = ^head_ev.code;
  assign sw_state    = state_q;
  assign ev_overflow = ov_q;
  assign por_out     = por_q;

endmodule
